// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage of the MIPS pipeline. Owns the program counter,
// drives the combinational instruction ROM and registers the fetched word
// together with its PC into the IF/ID pipeline register. Handles stall,
// branch/jump redirect (optionally keeping the delay slot) and exception
// flush.
//
// Ports:
//   clk           in   1   system clock, rising edge
//   rst           in   1   synchronous reset, active-low
//   stall         in   1   hold PC and IF/ID this cycle
//   flush         in   1   exception/eret redirect, beats stall and branch
//   flush_target  in  32   PC loaded on flush
//   branch_valid  in   1   taken branch/jump resolved in ID
//   branch_target in  32   branch/jump destination
//   rom_ce        out  1   instruction ROM enable
//   rom_addr      out 32   instruction ROM byte address (the PC register)
//   rom_inst      in  32   ROM read data, combinational from rom_addr/rom_ce
//   id_pc         out 32   PC of the instruction held in IF/ID
//   id_inst       out 32   instruction held in IF/ID
//   id_valid      out  1   IF/ID holds a real instruction
// -----------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_target,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        id_valid_q, id_valid_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;

    // Redirect targets are forced onto a word boundary; misalignment is not
    // reported, the low bits are simply dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Outputs come straight from registers so nothing combinational reaches
    // the ROM address/enable from the pipeline control inputs.
    assign rom_ce   = (state_q == RUN);
    assign rom_addr = pc_q;
    assign id_pc    = id_pc_q;
    assign id_inst  = id_inst_q;
    assign id_valid = id_valid_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        id_pc_d       = id_pc_q;
        id_inst_d     = id_inst_q;
        id_valid_d    = id_valid_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;

        case (state_q)
            IDLE: begin
                // First cycle out of reset: PC stays at RESET_PC so that
                // address is presented to the ROM for a full RUN cycle.
                state_d    = RUN;
                id_pc_d    = 32'h0;
                id_inst_d  = 32'h0;
                id_valid_d = 1'b0;
            end

            RUN: begin
                if (flush) begin
                    pc_d         = word_align(flush_target);
                    id_pc_d      = 32'h0;
                    id_inst_d    = 32'h0;
                    id_valid_d   = 1'b0;
                    pend_valid_d = 1'b0;
                end else if (stall) begin
                    // A branch resolved while stalled must not be lost; the
                    // most recent one wins if several arrive.
                    if (branch_valid) begin
                        pend_target_d = word_align(branch_target);
                        pend_valid_d  = 1'b1;
                    end
                end else begin
                    if (pend_valid_q) begin
                        pc_d         = pend_target_q;
                        pend_valid_d = 1'b0;
                    end else if (branch_valid) begin
                        pc_d = word_align(branch_target);
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end

                    // The word fetched in a redirect cycle is the delay slot;
                    // without delay slots it becomes a bubble.
                    if (!DELAY_SLOT && (pend_valid_q || branch_valid)) begin
                        id_pc_d    = 32'h0;
                        id_inst_d  = 32'h0;
                        id_valid_d = 1'b0;
                    end else begin
                        id_pc_d    = pc_q;
                        id_inst_d  = rom_inst;
                        id_valid_d = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            id_pc_q       <= 32'h0;
            id_inst_q     <= 32'h0;
            id_valid_q    <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            id_pc_q       <= id_pc_d;
            id_inst_q     <= id_inst_d;
            id_valid_q    <= id_valid_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] flush_target;
    logic        branch_valid;
    logic [31:0] branch_target;

    logic        rom_ce0, rom_ce1;
    logic [31:0] rom_addr0, rom_addr1;
    logic [31:0] rom_inst0, rom_inst1;
    logic [31:0] id_pc0, id_pc1;
    logic [31:0] id_inst0, id_inst1;
    logic        id_valid0, id_valid1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // ROM contents: words 0..3 are 0x11,0x22,0x33,0x44, everything else a hash.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a < 32'd16) return ((a >> 2) + 32'd1) * 32'h11;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign rom_inst0 = rom_ce0 ? rom_word(rom_addr0) : 32'h0;
    assign rom_inst1 = rom_ce1 ? rom_word(rom_addr1) : 32'h0;

    // dut0: delay slot kept, reset PC 0.  dut1: delay slot squashed, reset PC 0x100.
    if_fetch_stage #(.RESET_PC(32'h0000_0000), .DELAY_SLOT(1'b1)) dut0 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .flush_target(flush_target), .branch_valid(branch_valid),
        .branch_target(branch_target), .rom_ce(rom_ce0), .rom_addr(rom_addr0),
        .rom_inst(rom_inst0), .id_pc(id_pc0), .id_inst(id_inst0), .id_valid(id_valid0)
    );

    if_fetch_stage #(.RESET_PC(32'h0000_0100), .DELAY_SLOT(1'b0)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .flush_target(flush_target), .branch_valid(branch_valid),
        .branch_target(branch_target), .rom_ce(rom_ce1), .rom_addr(rom_addr1),
        .rom_inst(rom_inst1), .id_pc(id_pc1), .id_inst(id_inst1), .id_valid(id_valid1)
    );

    logic [97:0] obs [2];
    assign obs[0] = {rom_ce0, rom_addr0, id_valid0, id_pc0, id_inst0};
    assign obs[1] = {rom_ce1, rom_addr1, id_valid1, id_pc1, id_inst1};

    // ---------------- reference model (transaction level) ----------------
    logic        m_run  [2];
    logic [31:0] m_pc   [2];
    logic        m_vld  [2];
    logic [31:0] m_ipc  [2];
    logic [31:0] m_inst [2];
    logic        m_pv   [2];
    logic [31:0] m_pt   [2];

    function automatic logic [31:0] model_reset_pc(input int k);
        return (k == 0) ? 32'h0 : 32'h100;
    endfunction

    function automatic logic [97:0] expv(input int k);
        return {m_run[k], m_pc[k], m_vld[k], m_ipc[k], m_inst[k]};
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [31:0] w;
            logic        taken;
            logic [31:0] dest;
            w     = rom_word(m_pc[k]);
            taken = m_pv[k] || branch_valid;
            dest  = m_pv[k] ? m_pt[k] : {branch_target[31:2], 2'b00};
            if (!rst) begin
                m_run[k] = 1'b0; m_pc[k] = model_reset_pc(k);
                m_vld[k] = 1'b0; m_ipc[k] = 0; m_inst[k] = 0;
                m_pv[k] = 1'b0; m_pt[k] = 0;
            end else if (!m_run[k]) begin
                m_run[k] = 1'b1;
                m_vld[k] = 1'b0; m_ipc[k] = 0; m_inst[k] = 0;
            end else if (flush) begin
                m_pc[k] = {flush_target[31:2], 2'b00};
                m_vld[k] = 1'b0; m_ipc[k] = 0; m_inst[k] = 0;
                m_pv[k] = 1'b0;
            end else if (stall) begin
                if (branch_valid) begin
                    m_pt[k] = {branch_target[31:2], 2'b00};
                    m_pv[k] = 1'b1;
                end
            end else begin
                // The fetched word retires unless it is a squashed redirect slot.
                if (!taken || k == 0) begin
                    m_vld[k] = 1'b1; m_ipc[k] = m_pc[k]; m_inst[k] = w;
                end else begin
                    m_vld[k] = 1'b0; m_ipc[k] = 0; m_inst[k] = 0;
                end
                m_pc[k] = taken ? dest : m_pc[k] + 32'd4;
                m_pv[k] = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; branch_valid = 0;
        flush_target = 0; branch_target = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] ea [3];
        logic [31:0] ei [3];
        ea[0] = 32'h0; ea[1] = 32'h4;  ea[2] = 32'h8;
        ei[0] = 32'h0; ei[1] = 32'h11; ei[2] = 32'h22;
        rst = 0; idle_inputs();
        step(); step();
        checks++;
        if ({rom_ce0, rom_addr0, id_valid0, id_pc0, id_inst0} !== 98'h0) begin
            errors++; $display("FAIL reset_state dut0 got=%h exp=0", obs[0]);
        end
        checks++;
        if ({rom_ce1, rom_addr1, id_valid1} !== {1'b0, 32'h100, 1'b0}) begin
            errors++; $display("FAIL reset_state dut1 got ce=%b addr=%h v=%b exp ce=0 addr=100 v=0", rom_ce1, rom_addr1, id_valid1);
        end
        rst = 1;
        #1;
        checks++;
        if (rom_ce0 !== 1'b0) begin
            errors++; $display("FAIL reset_idle_ce got=%b exp=0", rom_ce0);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (rom_ce0 !== 1'b1 || rom_addr0 !== ea[i] || id_inst0 !== ei[i] || id_valid0 !== (i > 0)) begin
                errors++;
                $display("FAIL reset_release[%0d] got ce=%b addr=%h inst=%h v=%b exp ce=1 addr=%h inst=%h v=%b",
                         i, rom_ce0, rom_addr0, id_inst0, id_valid0, ea[i], ei[i], (i > 0));
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== expv(k)) begin
                    errors++; $display("FAIL reset_release_model dut%0d got=%h exp=%h", k, obs[k], expv(k));
                end
            end
        end
    endtask

    task automatic test_stall();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (rom_addr0 !== 32'h8 || id_pc0 !== 32'h4 || id_inst0 !== 32'h22) begin
                errors++;
                $display("FAIL stall_hold[%0d] got addr=%h pc=%h inst=%h exp addr=8 pc=4 inst=22", i, rom_addr0, id_pc0, id_inst0);
            end
        end
        stall = 0;
        step();
        checks++;
        if (rom_addr0 !== 32'hC || id_pc0 !== 32'h8 || id_inst0 !== 32'h33) begin
            errors++; $display("FAIL stall_resume got addr=%h pc=%h inst=%h exp addr=c pc=8 inst=33", rom_addr0, id_pc0, id_inst0);
        end
        step();
        checks++;
        if (rom_addr0 !== 32'h10 || id_inst0 !== 32'h44) begin
            errors++; $display("FAIL stall_resume2 got addr=%h inst=%h exp addr=10 inst=44", rom_addr0, id_inst0);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== expv(k)) begin
                errors++; $display("FAIL stall_model dut%0d got=%h exp=%h", k, obs[k], expv(k));
            end
        end
    endtask

    task automatic test_branch();
        branch_valid = 1; branch_target = 32'h40;
        step();
        branch_valid = 0;
        checks++;
        if (rom_addr0 !== 32'h40 || id_pc0 !== 32'h10 || id_inst0 !== rom_word(32'h10) || id_valid0 !== 1'b1) begin
            errors++;
            $display("FAIL branch_delay_slot got addr=%h pc=%h inst=%h v=%b exp addr=40 pc=10 inst=%h v=1",
                     rom_addr0, id_pc0, id_inst0, id_valid0, rom_word(32'h10));
        end
        checks++;
        if (rom_addr1 !== 32'h40 || id_valid1 !== 1'b0) begin
            errors++; $display("FAIL branch_no_slot got addr=%h v=%b exp addr=40 v=0", rom_addr1, id_valid1);
        end
        step();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== expv(k)) begin
                errors++; $display("FAIL branch_model dut%0d got=%h exp=%h", k, obs[k], expv(k));
            end
        end
    endtask

    task automatic test_pending_branch();
        logic [31:0] held;
        logic [31:0] tgt [2];
        tgt[0] = 32'h80; tgt[1] = 32'h83;
        for (int r = 0; r < 2; r++) begin
            held = rom_addr0;
            stall = 1; branch_valid = 1; branch_target = tgt[r];
            step();
            branch_valid = 0;
            step();
            checks++;
            if (rom_addr0 !== held) begin
                errors++; $display("FAIL pend_hold[%0d] got addr=%h exp=%h", r, rom_addr0, held);
            end
            stall = 0;
            step();
            checks++;
            if (rom_addr0 !== 32'h80 || rom_addr1 !== 32'h80) begin
                errors++; $display("FAIL pend_apply[%0d] got addr0=%h addr1=%h exp 80", r, rom_addr0, rom_addr1);
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== expv(k)) begin
                    errors++; $display("FAIL pend_model[%0d] dut%0d got=%h exp=%h", r, k, obs[k], expv(k));
                end
            end
        end
        // Two branches within one stall: the later one wins.
        stall = 1; branch_valid = 1; branch_target = 32'h200;
        step();
        branch_target = 32'h2C4;
        step();
        stall = 0; branch_valid = 0;
        step();
        checks++;
        if (rom_addr0 !== 32'h2C4) begin
            errors++; $display("FAIL pend_overwrite got addr=%h exp=2c4", rom_addr0);
        end
    endtask

    task automatic test_flush();
        stall = 1; branch_valid = 1; branch_target = 32'h40;
        step();
        flush = 1; flush_target = 32'h181;
        step();
        checks++;
        if (rom_addr0 !== 32'h180 || id_valid0 !== 1'b0 || id_inst0 !== 32'h0 || id_pc0 !== 32'h0) begin
            errors++;
            $display("FAIL flush_apply got addr=%h v=%b pc=%h inst=%h exp addr=180 v=0 pc=0 inst=0", rom_addr0, id_valid0, id_pc0, id_inst0);
        end
        flush = 0; stall = 0; branch_valid = 0;
        step();
        checks++;
        if (rom_addr0 !== 32'h184 || rom_addr1 !== 32'h184) begin
            errors++; $display("FAIL flush_drops_pending got addr0=%h addr1=%h exp 184", rom_addr0, rom_addr1);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== expv(k)) begin
                errors++; $display("FAIL flush_model dut%0d got=%h exp=%h", k, obs[k], expv(k));
            end
        end
    endtask

    task automatic test_wrap();
        branch_valid = 1; branch_target = 32'hFFFF_FFFC;
        step();
        branch_valid = 0;
        checks++;
        if (rom_addr0 !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_setup got addr=%h exp=fffffffc", rom_addr0);
        end
        step();
        checks++;
        if (rom_addr0 !== 32'h0 || id_pc0 !== 32'hFFFF_FFFC || id_valid0 !== 1'b1) begin
            errors++; $display("FAIL wrap got addr=%h pc=%h v=%b exp addr=0 pc=fffffffc v=1", rom_addr0, id_pc0, id_valid0);
        end
    endtask

    task automatic test_reset_mid();
        stall = 1; branch_valid = 1; branch_target = 32'h300;
        step();
        rst = 0; stall = 0; flush = 1; flush_target = 32'h500;
        step();
        checks++;
        if (rom_ce0 !== 1'b0 || id_valid0 !== 1'b0 || rom_addr0 !== 32'h0 || rom_addr1 !== 32'h100) begin
            errors++;
            $display("FAIL reset_mid got ce=%b v=%b addr0=%h addr1=%h exp ce=0 v=0 addr0=0 addr1=100", rom_ce0, id_valid0, rom_addr0, rom_addr1);
        end
        rst = 1;
        step();
        checks++;
        if (rom_ce0 !== 1'b1 || rom_addr0 !== 32'h0 || id_valid0 !== 1'b0) begin
            errors++; $display("FAIL idle_ignores_inputs got ce=%b addr=%h v=%b exp ce=1 addr=0 v=0", rom_ce0, rom_addr0, id_valid0);
        end
        idle_inputs();
        step();
        checks++;
        if (rom_addr0 !== 32'h4 || id_inst0 !== 32'h11) begin
            errors++; $display("FAIL reset_mid_resume got addr=%h inst=%h exp addr=4 inst=11", rom_addr0, id_inst0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 63) != 0);
            stall        = ($urandom_range(0, 3) == 0);
            flush        = ($urandom_range(0, 15) == 0);
            branch_valid = ($urandom_range(0, 4) == 0);
            flush_target = $urandom;
            branch_target = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== expv(k)) begin
                    errors++; $display("FAIL random[%0d] dut%0d got=%h exp=%h", i, k, obs[k], expv(k));
                end
            end
        end
        idle_inputs();
        rst = 1;
    endtask

    initial begin
        rst = 0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_stall();
        test_branch();
        test_pending_branch();
        test_flush();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
